// File: rtl/dot_acc_4x4_pkg.sv
// Shared types and defaults for the dot-product accumulator that sits behind the 4x4 multiplier.
package dot_acc_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StHold  = 2'd2
    } state_t;

    localparam int unsigned DEF_ACC_W   = 12;
    localparam int unsigned DEF_MAX_LEN = 16;

endpackage

// File: rtl/dot_acc_4x4_sat_adder.sv
// Combinational unsigned add of an 8-bit product onto a W-bit sum, clamped to all-ones on carry-out.
module sat_adder #(
    parameter int unsigned W = 12
) (
    input  logic [W-1:0] a_i,
    input  logic [7:0]   b_i,
    output logic [W-1:0] sum_o,
    output logic         sat_o
);

    logic [W:0] full;

    always_comb begin
        full  = {1'b0, a_i} + (W+1)'(b_i);
        sat_o = full[W];
        sum_o = full[W] ? '1 : full[W-1:0];
    end

endmodule

// File: rtl/dot_acc_4x4.sv
// Frames 8-bit products into a saturated dot-product sum and presents it on a valid/ready port.
module dot_acc_4x4
    import dot_acc_pkg::*;
#(
    parameter int unsigned ACC_W   = DEF_ACC_W,
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    localparam int unsigned CNT_W  = $clog2(MAX_LEN + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic [7:0]       prod_i,
    input  logic             in_valid_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic [ACC_W-1:0] result_o,
    output logic [CNT_W-1:0] out_count_o,
    output logic             out_overflow_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o
);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               first;
    logic               close;
    logic [ACC_W-1:0]   add_a;
    logic [ACC_W-1:0]   beat_sum;
    logic               beat_sat;
    logic               beat_ovf;
    logic [CNT_W-1:0]   beat_cnt;

    // The first beat of a frame adds onto zero, so one adder serves both IDLE and ACCUM.
    sat_adder #(
        .W(ACC_W)
    ) u_sat_adder (
        .a_i  (add_a),
        .b_i  (prod_i),
        .sum_o(beat_sum),
        .sat_o(beat_sat)
    );

    always_comb begin
        in_ready_o = (state_q != StHold) && !clr_i;
        accept     = in_valid_i && in_ready_o;
        first      = (state_q == StIdle);
        add_a      = first ? '0 : acc_q;
        beat_ovf   = first ? beat_sat : (ovf_q | beat_sat);
        beat_cnt   = first ? CNT_W'(1) : count_q + CNT_W'(1);
        close      = in_last_i || (beat_cnt == CNT_W'(MAX_LEN));
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        result_d    = result_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        if (clr_i) begin
            state_d     = StIdle;
            acc_d       = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                StIdle, StAccum: begin
                    if (accept) begin
                        acc_d   = beat_sum;
                        count_d = beat_cnt;
                        ovf_d   = beat_ovf;
                        if (close) begin
                            result_d    = beat_sum;
                            out_count_d = beat_cnt;
                            out_ovf_d   = beat_ovf;
                            out_valid_d = 1'b1;
                            state_d     = StHold;
                        end else begin
                            state_d = StAccum;
                        end
                    end
                end
                StHold: begin
                    if (out_ready_i) begin
                        out_valid_d = 1'b0;
                        state_d     = StIdle;
                        acc_d       = '0;
                        count_d     = '0;
                        ovf_d       = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            result_q    <= result_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result_o       = result_q;
    assign out_count_o    = out_count_q;
    assign out_overflow_o = out_ovf_q;
    assign out_valid_o    = out_valid_q;
    assign busy_o         = (state_q == StAccum);

endmodule

// File: tb/tb_dot_acc_4x4.sv
// Scoreboard bench for dot_acc_4x4: a behavioural frame model pushes expected results, a monitor pops them.
module tb_dot_acc_4x4;

    typedef struct packed {
        logic [31:0] sum;
        logic [31:0] cnt;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [7:0]  prod;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [11:0] result;
    logic [4:0]  out_count;
    logic        out_overflow;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    logic [7:0]  p10;
    logic        v10;
    logic        l10;
    logic        rdy10;
    logic [9:0]  result10;
    logic [4:0]  count10;
    logic        ovf10;
    logic        valid10;
    logic        busy10;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    int   m_sum = 0;
    int   m_cnt = 0;
    bit   m_ovf = 1'b0;

    dot_acc_4x4 dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clr_i         (clr),
        .prod_i        (prod),
        .in_valid_i    (in_valid),
        .in_last_i     (in_last),
        .in_ready_o    (in_ready),
        .result_o      (result),
        .out_count_o   (out_count),
        .out_overflow_o(out_overflow),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .busy_o        (busy)
    );

    dot_acc_4x4 #(
        .ACC_W(10)
    ) dut10 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clr_i         (1'b0),
        .prod_i        (p10),
        .in_valid_i    (v10),
        .in_last_i     (l10),
        .in_ready_o    (rdy10),
        .result_o      (result10),
        .out_count_o   (count10),
        .out_overflow_o(ovf10),
        .out_valid_o   (valid10),
        .out_ready_i   (1'b1),
        .busy_o        (busy10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference frame model for ACC_W=12, MAX_LEN=16.
    task automatic model_beat(input logic [7:0] p, input logic last);
        if (m_cnt == 0) begin
            m_sum = 0;
            m_ovf = 1'b0;
        end
        m_sum = m_sum + int'(p);
        if (m_sum > 4095) begin
            m_sum = 4095;
            m_ovf = 1'b1;
        end
        m_cnt++;
        if (last || m_cnt == 16) begin
            sb.push_back('{sum: m_sum, cnt: m_cnt, ovf: m_ovf});
            m_cnt = 0;
        end
    endtask

    // Called just after a rising edge; returns on the rising edge that accepts the beat.
    task automatic beat(input logic [7:0] p, input logic last);
        int n = 0;
        #1;
        prod     = p;
        in_valid = 1'b1;
        in_last  = last;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 20) begin
                n_vec++;
                n_err++;
                $display("FAIL beat_timeout: in_ready stayed 0, expected 1");
                break;
            end
            @(negedge clk);
        end
        model_beat(p, last);
        @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: result %0d count %0d with no frame expected",
                         result, out_count);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_result", 32'(result), e.sum);
                check("sb_count", 32'(out_count), e.cnt);
                check("sb_ovf", 32'(out_overflow), 32'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clr = 1'b0;
        prod = '0;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        p10 = '0;
        v10 = 1'b0;
        l10 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", 32'(result), 0);
        check("rst_count", 32'(out_count), 0);
        check("rst_ovf", 32'(out_overflow), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);

        // Three beats of 225 closed by in_last.
        beat(8'd225, 1'b0);
        #1;
        check("t1_busy", 32'(busy), 1);
        beat(8'd225, 1'b0);
        beat(8'd225, 1'b1);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        check("t1_latency_valid", 32'(out_valid), 1);
        check("t1_busy_after", 32'(busy), 0);
        check("t1_in_ready_hold", 32'(in_ready), 0);
        @(posedge clk);

        // Sixteen beats of 1 with no in_last: forced close.
        for (int i = 0; i < 16; i++) beat(8'd1, 1'b0);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("t3_autoclose_valid", 32'(out_valid), 1);
        check("t3_in_ready", 32'(in_ready), 0);
        @(posedge clk);

        // Frame {6,9} stalled by out_ready=0 for five cycles while a beat is offered.
        #1 out_ready = 1'b0;
        beat(8'd6, 1'b0);
        beat(8'd9, 1'b1);
        #1;
        prod = 8'd99;
        in_valid = 1'b1;
        in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(out_valid), 1);
            check("t4_hold_result", 32'(result), 15);
            check("t4_hold_count", 32'(out_count), 2);
            check("t4_hold_in_ready", 32'(in_ready), 0);
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("t4_drain_valid", 32'(out_valid), 0);
        check("t4_drain_in_ready", 32'(in_ready), 1);
        check("t4_drain_result_kept", 32'(result), 15);
        @(posedge clk);

        // Reset mid-frame after two beats of 100.
        beat(8'd100, 1'b0);
        beat(8'd100, 1'b0);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("t5_busy", 32'(busy), 1);
        #1 rst_n = 1'b0;
        m_cnt = 0;
        #1;
        check("t5_rst_result", 32'(result), 0);
        check("t5_rst_count", 32'(out_count), 0);
        check("t5_rst_valid", 32'(out_valid), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        beat(8'd7, 1'b1);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        @(posedge clk);

        // clr while holding a result of 50; the beat offered during clr is dropped.
        #1 out_ready = 1'b0;
        beat(8'd50, 1'b1);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        check("t6_hold_result", 32'(result), 50);
        check("t6_hold_valid", 32'(out_valid), 1);
        @(posedge clk);
        #1;
        clr = 1'b1;
        prod = 8'd4;
        in_valid = 1'b1;
        in_last = 1'b1;
        @(negedge clk);
        check("t6_clr_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        sb.delete();
        m_cnt = 0;
        @(negedge clk);
        check("t6_clr_valid", 32'(out_valid), 0);
        check("t6_clr_busy", 32'(busy), 0);
        check("t6_clr_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        beat(8'd4, 1'b1);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        @(posedge clk);

        // ACC_W=10 instance: five beats of 225 saturate at 1023.
        for (int i = 0; i < 5; i++) begin
            #1;
            p10 = 8'd225;
            v10 = 1'b1;
            l10 = (i == 4);
            @(posedge clk);
        end
        #1;
        v10 = 1'b0;
        l10 = 1'b0;
        @(negedge clk);
        check("t2_valid", 32'(valid10), 1);
        check("t2_result", 32'(result10), 1023);
        check("t2_count", 32'(count10), 5);
        check("t2_ovf", 32'(ovf10), 1);
        @(posedge clk);

        repeat (2) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dot_acc_4x4.md
Name: dot_acc_4x4

Overview:
- Sequential accumulator directly downstream of the 4x4 combinational multiplier.
- Consumes one 8-bit unsigned product per accepted beat and sums a frame of products into a dot-product result.
- Presents the result on a valid/ready output port.
- A frame closes on in_last, or automatically after MAX_LEN beats.

Parameters:
- ACC_W, 12, accumulator/result width in bits; legal range is ACC_W >= 8.
- MAX_LEN, 16, maximum beats per frame before forced close; legal range is MAX_LEN >= 1.
- CNT_W, $clog2(MAX_LEN+1), beat-count width; derived, not overridden.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous abort; discards the partial frame and any pending result.
- prod  input  8  unsigned product from the multiplier output M.
- in_valid  input  1  prod is valid this cycle.
- in_last  input  1  final beat of the frame; qualified by in_valid.
- in_ready  output  1  block accepts a beat this cycle.
- result  output  ACC_W  accumulated sum, saturated.
- out_count  output  CNT_W  number of beats in the reported frame.
- out_overflow  output  1  saturation occurred within the reported frame.
- out_valid  output  1  result, out_count and out_overflow are valid.
- out_ready  input  1  downstream accepts the result.
- busy  output  1  a frame is in progress (state ACCUM).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, acc=0, count=0, ovf=0.
  - result=0, out_count=0, out_overflow=0, out_valid=0, busy=0.
  - in_ready=1, because in_ready is combinational: in_ready = (state != HOLD) && !clr.
- States:
  - IDLE: no partial sum held.
  - ACCUM: frame open.
  - HOLD: result presented, waiting for out_ready.
- Beat accept: in_valid && in_ready. With in_valid and in_ready low, nothing happens; upstream must hold its data.
- Accepted beat in IDLE:
  - acc = {0, prod}, count = 1, ovf = 0.
  - Go to ACCUM, unless the frame closes on this beat.
- Accepted beat in ACCUM:
  - acc = sat(acc + zero-extended prod), count += 1.
  - ovf |= carry-out of the add.
- Saturation: if the true sum exceeds 2^ACC_W-1, acc becomes all-ones and ovf stays set until the frame is reported.
- Frame close on an accepted beat with in_last=1, or when the new count equals MAX_LEN:
  - Next cycle: result, out_count and out_overflow are loaded; out_valid=1; state=HOLD.
  - Latency from the closing beat to out_valid is 1 cycle.
  - A single-beat frame (in_last on the first beat) is legal and gives result=prod, out_count=1.
- HOLD:
  - in_ready=0.
  - result, out_count and out_overflow are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid=0 next cycle, state=IDLE, acc and count cleared.
  - out_valid and in_ready are never both high, so there is no same-cycle accept/drain overlap.
- Output registers keep their last values after a drain; only out_valid drops.
- clr has priority over every other event:
  - Next cycle: state=IDLE, acc=0, count=0, ovf=0, out_valid=0.
  - Beats presented during clr are dropped (in_ready=0).
- rst_n asserted mid-frame or in HOLD: the partial or pending result is lost and all outputs go to reset values immediately.
- Arithmetic is unsigned only; there is no wrap-around of acc.

Decomposition:
- Package dot_acc_pkg:
  - state enum state_t {IDLE, ACCUM, HOLD}.
  - Default constants DEF_ACC_W=12, DEF_MAX_LEN=16.
- Sub-module sat_adder #(W):
  - Inputs: a[W], b[8].
  - Outputs: sum[W], sat (flag).
  - Purely combinational; instantiated once for the acc update.
- The multiplier itself stays outside this block; prod connects to its M output at the integration level.

Test Plan:
- Three beats of prod=225 (15x15), in_last on the third -> one cycle later out_valid=1, result=675, out_count=3, out_overflow=0.
- ACC_W=10, five beats of prod=225 with in_last on the fifth -> result=1023, out_overflow=1, out_count=5.
- Sixteen beats of prod=1 with in_last never asserted -> auto-close, result=16, out_count=16; in_ready=0 on the following cycle.
- Frame of prod {6,9} (2x3, 3x3), hold out_ready=0 for 5 cycles:
  - result=15 stays stable; in_ready=0; in_valid beats presented meanwhile are not accepted.
  - out_ready=1 -> out_valid falls next cycle and in_ready=1.
- Two beats of prod=100, then rst_n low for 1 cycle mid-frame -> outputs return to reset values immediately; a following single beat prod=7 with in_last -> result=7, out_count=1.
- In HOLD with result=50, assert clr for 1 cycle -> out_valid=0 next cycle, state IDLE; a beat of prod=4 with in_last presented during clr is dropped; the same beat repeated after clr -> result=4.
